// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst adapter: FSM states, burst/resp encodings, axsize helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } axi_adapter_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  // Normal non-cacheable bufferable: lets the MIG merge/reorder as it likes.
  localparam logic [3:0] AXI_CACHE_NC_BUF = 4'b0011;

  // AXI size code: log2 of the bytes per beat.
  function automatic logic [2:0] axsize_from_width(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_burst_adapter.sv
// Turns a level-held read/write request into one line-aligned AXI4 INCR burst of BURST_LEN beats.
// Latency: ar/awvalid 1 cycle after request; dramValid 1 cycle after last R beat or B handshake.
// Backpressure: every valid holds with stable payload until ready; beat index advances only on handshake.
module axi_burst_adapter
  import axi_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          BURST_LEN = 8,
  parameter logic [3:0]  AXI_ID    = 4'd0,
  localparam int         BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  // client side
  input  logic [31:0]           dramAddress,
  input  logic                  readEnable,
  input  logic                  writeEnable,
  input  logic [DATA_W-1:0]     dramWriteData,
  output logic [BEAT_W-1:0]     dramWriteBeat,
  output logic [DATA_W-1:0]     dramReadData,
  output logic                  dramReadBeatValid,
  output logic [BEAT_W-1:0]     dramReadBeat,
  output logic                  dramValid,
  output logic                  dramError,
  // AXI write address
  output logic [3:0]            m_axi_awid,
  output logic [31:0]           m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI write data
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI write response
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI read address
  output logic [3:0]            m_axi_arid,
  output logic [31:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI read data
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int              LINE_LSB  = $clog2(BURST_LEN * DATA_W / 8);
  localparam logic [31:0]     LINE_MASK = ~((32'd1 << LINE_LSB) - 32'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [7:0]      AXLEN     = 8'(BURST_LEN - 1);
  localparam logic [2:0]      AXSIZE    = axsize_from_width(DATA_W);

  axi_adapter_state_t state_q, state_d;
  logic [BEAT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_vld_q, rd_vld_d;
  logic [BEAT_W-1:0]  rd_beat_q, rd_beat_d;

  logic in_ar, in_r, in_aw, in_w, in_b, last_beat;

  assign in_ar     = (state_q == ST_AR);
  assign in_r      = (state_q == ST_R);
  assign in_aw     = (state_q == ST_AW);
  assign in_w      = (state_q == ST_W);
  assign in_b      = (state_q == ST_B);
  assign last_beat = (cnt_q == LAST_BEAT);

  // Next-state, shared beat counter, address latch, error accumulation and read capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    rd_beat_d = rd_beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (writeEnable) begin
          state_d = ST_AW;
          addr_d  = dramAddress & LINE_MASK;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (readEnable) begin
          state_d = ST_AR;
          addr_d  = dramAddress & LINE_MASK;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_AR: if (m_axi_arready) state_d = ST_R;
      ST_R: begin
        if (m_axi_rvalid) begin
          rd_data_d = m_axi_rdata;
          rd_vld_d  = 1'b1;
          rd_beat_d = cnt_q;
          // rlast must coincide exactly with our own beat count.
          if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat)) err_d = 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_AW: if (m_axi_awready) state_d = ST_W;
      ST_W: begin
        if (m_axi_wready) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (!(readEnable || writeEnable)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears the whole transaction at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_beat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      rd_beat_q <= rd_beat_d;
    end
  end

  // Client-facing outputs.
  assign dramWriteBeat     = cnt_q;
  assign dramReadData      = rd_data_q;
  assign dramReadBeatValid = rd_vld_q;
  assign dramReadBeat      = rd_beat_q;
  assign dramValid         = (state_q == ST_DONE);
  assign dramError         = err_q;

  // AXI outputs are decoded from state so every field idles at zero.
  assign m_axi_awid    = in_aw ? AXI_ID : 4'd0;
  assign m_axi_awaddr  = in_aw ? addr_q : 32'd0;
  assign m_axi_awlen   = in_aw ? AXLEN : 8'd0;
  assign m_axi_awsize  = in_aw ? AXSIZE : 3'd0;
  assign m_axi_awburst = in_aw ? AXI_BURST_INCR : 2'b00;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = in_aw ? AXI_CACHE_NC_BUF : 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = in_aw;

  assign m_axi_wdata   = in_w ? dramWriteData : '0;
  assign m_axi_wstrb   = in_w ? '1 : '0;
  assign m_axi_wlast   = in_w && last_beat;
  assign m_axi_wvalid  = in_w;

  assign m_axi_bready  = in_b;

  assign m_axi_arid    = in_ar ? AXI_ID : 4'd0;
  assign m_axi_araddr  = in_ar ? addr_q : 32'd0;
  assign m_axi_arlen   = in_ar ? AXLEN : 8'd0;
  assign m_axi_arsize  = in_ar ? AXSIZE : 3'd0;
  assign m_axi_arburst = in_ar ? AXI_BURST_INCR : 2'b00;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = in_ar ? AXI_CACHE_NC_BUF : 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = in_ar;

  assign m_axi_rready  = in_r;

endmodule

// File: tb/tb_axi_burst_adapter.sv
// Bench for axi_burst_adapter: 8-beat instance driven from a vector table, plus a 1-beat instance.
// Bench acts as client and as a small memory-backed AXI slave.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_burst_adapter;
  import axi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  int checks = 0;
  int errors = 0;

  // ---------------- 8-beat instance ----------------
  logic [31:0] dramAddress;
  logic        readEnable, writeEnable;
  logic [31:0] dramWriteData;
  logic [2:0]  dramWriteBeat, dramReadBeat;
  logic [31:0] dramReadData;
  logic        dramReadBeatValid, dramValid, dramError;
  logic [3:0]  awid, arid, awcache, arcache;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock, awvalid, awready, arvalid, arready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;
  logic [31:0] data_base;

  // Client presents beat data combinationally from the beat index.
  assign dramWriteData = data_base + {29'd0, dramWriteBeat};

  axi_burst_adapter #(.DATA_W(32), .BURST_LEN(8), .AXI_ID(4'd0)) u_dut (
    .clk(clk), .rstn(rstn),
    .dramAddress(dramAddress), .readEnable(readEnable), .writeEnable(writeEnable),
    .dramWriteData(dramWriteData), .dramWriteBeat(dramWriteBeat),
    .dramReadData(dramReadData), .dramReadBeatValid(dramReadBeatValid),
    .dramReadBeat(dramReadBeat), .dramValid(dramValid), .dramError(dramError),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // ---------------- 1-beat instance ----------------
  logic [31:0] addr1;
  logic        ren1, wen1;
  logic [31:0] wrdata1;
  logic        wbeat1, rbeat1;
  logic [31:0] rddata1;
  logic        rbvld1, valid1, err1;
  logic [3:0]  awid1, arid1, awcache1, arcache1;
  logic [31:0] awaddr1, araddr1;
  logic [7:0]  awlen1, arlen1;
  logic [2:0]  awsize1, arsize1, awprot1, arprot1;
  logic [1:0]  awburst1, arburst1;
  logic        awlock1, arlock1, awvalid1, awready1, arvalid1, arready1;
  logic [31:0] wdata1;
  logic [3:0]  wstrb1;
  logic        wlast1, wvalid1, wready1;
  logic [1:0]  bresp1, rresp1;
  logic        bvalid1, bready1;
  logic [31:0] rdata1;
  logic        rlast1, rvalid1, rready1;

  axi_burst_adapter #(.DATA_W(32), .BURST_LEN(1), .AXI_ID(4'd0)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .dramAddress(addr1), .readEnable(ren1), .writeEnable(wen1),
    .dramWriteData(wrdata1), .dramWriteBeat(wbeat1),
    .dramReadData(rddata1), .dramReadBeatValid(rbvld1),
    .dramReadBeat(rbeat1), .dramValid(valid1), .dramError(err1),
    .m_axi_awid(awid1), .m_axi_awaddr(awaddr1), .m_axi_awlen(awlen1), .m_axi_awsize(awsize1),
    .m_axi_awburst(awburst1), .m_axi_awlock(awlock1), .m_axi_awcache(awcache1),
    .m_axi_awprot(awprot1), .m_axi_awvalid(awvalid1), .m_axi_awready(awready1),
    .m_axi_wdata(wdata1), .m_axi_wstrb(wstrb1), .m_axi_wlast(wlast1),
    .m_axi_wvalid(wvalid1), .m_axi_wready(wready1),
    .m_axi_bresp(bresp1), .m_axi_bvalid(bvalid1), .m_axi_bready(bready1),
    .m_axi_arid(arid1), .m_axi_araddr(araddr1), .m_axi_arlen(arlen1), .m_axi_arsize(arsize1),
    .m_axi_arburst(arburst1), .m_axi_arlock(arlock1), .m_axi_arcache(arcache1),
    .m_axi_arprot(arprot1), .m_axi_arvalid(arvalid1), .m_axi_arready(arready1),
    .m_axi_rdata(rdata1), .m_axi_rresp(rresp1), .m_axi_rlast(rlast1),
    .m_axi_rvalid(rvalid1), .m_axi_rready(rready1)
  );

  // ---------------- slave memory (word addressed, 1 KiB) ----------------
  logic [31:0] mem [0:255];

  typedef struct {
    logic        wr;        // 1 = write burst
    logic        both;      // also raise readEnable during a write
    logic [31:0] addr;
    logic [31:0] base;      // data of beat k is base+k
    int          stall;     // cycles awready/arready held low
    logic        toggle;    // wready alternates low/high
    logic [1:0]  resp;      // bresp, or rresp on every read beat
    int          rlast_at;  // read beat carrying rlast
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one transaction; entered and left on a falling edge with the DUT idle.
  task automatic run_vec(input vec_t v);
    int k;
    int cyc;
    int base_idx;
    base_idx    = int'(v.exp_addr[9:2]);
    dramAddress = v.addr;
    data_base   = v.base;
    if (v.wr) begin
      writeEnable = 1'b1;
      readEnable  = v.both;
    end else begin
      readEnable  = 1'b1;
    end
    @(negedge clk);
    if (v.wr) begin
      chk("awvalid_latency", {31'd0, awvalid}, 32'd1);
      chk("awaddr", awaddr, v.exp_addr);
      chk("awlen", {24'd0, awlen}, 32'd7);
      chk("awsize", {29'd0, awsize}, 32'd2);
      chk("awburst", {30'd0, awburst}, 32'd1);
      chk("awcache", {28'd0, awcache}, 32'd3);
      if (v.both) chk("ar_behind_aw", {31'd0, arvalid}, 32'd0);
      chk("wvalid_before_aw", {31'd0, wvalid}, 32'd0);
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        chk("awvalid_hold", {31'd0, awvalid}, 32'd1);
        chk("awaddr_hold", awaddr, v.exp_addr);
      end
      awready = 1'b1;
      @(negedge clk);
      awready = 1'b0;
      k = 0;
      cyc = 0;
      while (k < 8 && cyc < 100) begin
        cyc++;
        if (wvalid) begin
          chk("wbeat", {29'd0, dramWriteBeat}, k);
          chk("wdata", wdata, v.base + k);
          chk("wlast", {31'd0, wlast}, {31'd0, k == 7});
          chk("wstrb", {28'd0, wstrb}, 32'hf);
          wready = v.toggle ? (cyc % 2 == 0) : 1'b1;
          if (wready) begin
            mem[base_idx + k] = wdata;
            k++;
          end
        end else begin
          wready = 1'b0;
        end
        @(negedge clk);
      end
      wready = 1'b0;
      chk("w_beats", k, 32'd8);
      chk("no_extra_wbeat", {31'd0, wvalid}, 32'd0);
      cyc = 0;
      while (!bready && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("bready", {31'd0, bready}, 32'd1);
      chk("valid_before_b", {31'd0, dramValid}, 32'd0);
      bvalid = 1'b1;
      bresp  = v.resp;
      @(negedge clk);
      bvalid = 1'b0;
      bresp  = 2'b00;
    end else begin
      chk("arvalid_latency", {31'd0, arvalid}, 32'd1);
      chk("araddr", araddr, v.exp_addr);
      chk("arlen", {24'd0, arlen}, 32'd7);
      chk("arsize", {29'd0, arsize}, 32'd2);
      chk("arburst", {30'd0, arburst}, 32'd1);
      chk("arcache", {28'd0, arcache}, 32'd3);
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        chk("arvalid_hold", {31'd0, arvalid}, 32'd1);
        chk("araddr_hold", araddr, v.exp_addr);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      cyc = 0;
      while (!rready && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("rready", {31'd0, rready}, 32'd1);
      for (int b = 0; b < 8; b++) begin
        rvalid = 1'b1;
        rdata  = mem[base_idx + b];
        rresp  = v.resp;
        rlast  = (b == v.rlast_at);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        chk("rbeat_pulse", {31'd0, dramReadBeatValid}, 32'd1);
        chk("rbeat_index", {29'd0, dramReadBeat}, b);
        chk("rbeat_data", dramReadData, v.base + b);
        chk("rd_valid_timing", {31'd0, dramValid}, {31'd0, b == 7});
      end
    end
    chk("dramValid", {31'd0, dramValid}, 32'd1);
    chk("dramError", {31'd0, dramError}, {31'd0, v.exp_err});
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    @(negedge clk);
    chk("valid_drop", {31'd0, dramValid}, 32'd0);
    chk("back_to_idle", 32'(u_dut.state_q), 32'(ST_IDLE));
  endtask

  initial begin
    //           wr  both addr       base      stl tgl resp   rl exp_addr   err
    vecs[0] = '{1'b1, 1'b0, 32'h104, 32'h1000, 0, 1'b0, 2'b00, 7, 32'h100, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h100, 32'h1000, 0, 1'b0, 2'b00, 7, 32'h100, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h2f8, 32'h5500, 0, 1'b1, 2'b00, 7, 32'h2e0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h2e4, 32'h5500, 5, 1'b0, 2'b00, 7, 32'h2e0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h04c, 32'h7700, 0, 1'b0, 2'b10, 7, 32'h040, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h040, 32'h7700, 0, 1'b0, 2'b00, 7, 32'h040, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h11f, 32'h1000, 0, 1'b0, 2'b00, 3, 32'h100, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h100, 32'h1000, 0, 1'b0, 2'b10, 7, 32'h100, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 32'h080, 32'h9900, 2, 1'b1, 2'b00, 7, 32'h080, 1'b0};

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rstn = 1'b0;
    dramAddress = 0; readEnable = 0; writeEnable = 0; data_base = 32'h1234_0000;
    awready = 0; wready = 0; bresp = 0; bvalid = 0; arready = 0;
    rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    addr1 = 0; ren1 = 0; wen1 = 0; wrdata1 = 32'hdead_beef;
    awready1 = 0; wready1 = 0; bresp1 = 0; bvalid1 = 0; arready1 = 0;
    rdata1 = 0; rresp1 = 0; rlast1 = 0; rvalid1 = 0;
    repeat (2) @(negedge clk);

    // Reset state: every output at zero, wdata gated despite live client data.
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_awlen", {24'd0, awlen}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_bready", {31'd0, bready}, 32'd0);
    chk("rst_valid", {31'd0, dramValid}, 32'd0);
    chk("rst_error", {31'd0, dramError}, 32'd0);
    chk("rst_wbeat", {29'd0, dramWriteBeat}, 32'd0);
    chk("rst_rbvld", {31'd0, dramReadBeatValid}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single-beat instance: read at 0x0.
    ren1 = 1'b1;
    @(negedge clk);
    chk("l1_arvalid", {31'd0, arvalid1}, 32'd1);
    chk("l1_araddr", araddr1, 32'd0);
    chk("l1_arlen", {24'd0, arlen1}, 32'd0);
    arready1 = 1'b1;
    @(negedge clk);
    arready1 = 1'b0;
    chk("l1_rready", {31'd0, rready1}, 32'd1);
    rvalid1 = 1'b1; rdata1 = 32'hcafe_0001; rlast1 = 1'b1;
    @(negedge clk);
    rvalid1 = 1'b0; rlast1 = 1'b0;
    chk("l1_pulse", {31'd0, rbvld1}, 32'd1);
    chk("l1_rbeat", {31'd0, rbeat1}, 32'd0);
    chk("l1_rdata", rddata1, 32'hcafe_0001);
    chk("l1_valid", {31'd0, valid1}, 32'd1);
    chk("l1_error", {31'd0, err1}, 32'd0);
    ren1 = 1'b0;
    @(negedge clk);
    chk("l1_pulse_single", {31'd0, rbvld1}, 32'd0);
    chk("l1_valid_drop", {31'd0, valid1}, 32'd0);

    // Table-driven bursts on the 8-beat instance.
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset asserted while read beat 4 is being delivered.
    readEnable = 1'b1;
    dramAddress = 32'h100;
    @(negedge clk);
    chk("rst_seq_arvalid", {31'd0, arvalid}, 32'd1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      rvalid = 1'b1;
      rdata  = mem[64 + b];
      @(negedge clk);
      rvalid = 1'b0;
    end
    chk("pre_rst_beat", {29'd0, dramReadBeat}, 32'd4);
    rstn = 1'b0;
    readEnable = 1'b0;
    #1;
    chk("arst_pulse", {31'd0, dramReadBeatValid}, 32'd0);
    chk("arst_rdata", dramReadData, 32'd0);
    chk("arst_rbeat", {29'd0, dramReadBeat}, 32'd0);
    chk("arst_rready", {31'd0, rready}, 32'd0);
    chk("arst_valid", {31'd0, dramValid}, 32'd0);
    chk("arst_state", 32'(u_dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
